// File: rtl/seg_msg_decoder.sv
// seg_msg_decoder: filters an active-low seven-segment bus and checks the letter stream against "HELLOASIC"
module seg_msg_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         seg_in,
  output logic [3:0]         char_code,
  output logic               char_valid,
  output logic               unknown,
  output logic               match,
  output logic [3:0]         progress,
  output logic [COUNT_W-1:0] msg_count
);
  localparam logic [7:0]         STABLE = 8'(STABLE_CYCLES);
  localparam logic [6:0]         BLANK  = 7'h7F;
  localparam logic [COUNT_W-1:0] ONE    = COUNT_W'(1);
  logic [6:0] w_samp, r_cand, r_acc;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [3:0] w_code, w_exp;
  logic       w_same, w_accept, w_ev, w_hit, w_last;
  assign w_samp    = seg_in[6:0];
  assign w_same    = w_samp == r_cand;
  assign w_cnt_nxt = !w_same ? 8'd1 : (r_cnt == STABLE ? r_cnt : r_cnt + 8'd1);
  assign w_accept  = w_same && w_cnt_nxt == STABLE && r_cand != r_acc;
  assign w_ev      = w_accept && w_samp != BLANK;
  assign w_hit     = w_code == w_exp;
  assign w_last    = progress == 4'd8;
  // Map the sampled active-low pattern to its character code; anything unlisted is 15.
  always_comb begin
    w_code = 4'd15;
    case (w_samp)
      7'h09: w_code = 4'd1;
      7'h06: w_code = 4'd2;
      7'h47: w_code = 4'd3;
      7'h40: w_code = 4'd4;
      7'h08: w_code = 4'd5;
      7'h12: w_code = 4'd6;
      7'h4F: w_code = 4'd7;
      7'h46: w_code = 4'd8;
      default: w_code = 4'd15;
    endcase
  end
  // Character expected at the current matcher index of H E L L O A S I C.
  always_comb begin
    w_exp = 4'd8;
    case (progress)
      4'd0: w_exp = 4'd1;
      4'd1: w_exp = 4'd2;
      4'd2: w_exp = 4'd3;
      4'd3: w_exp = 4'd3;
      4'd4: w_exp = 4'd4;
      4'd5: w_exp = 4'd5;
      4'd6: w_exp = 4'd6;
      4'd7: w_exp = 4'd7;
      default: w_exp = 4'd8;
    endcase
  end
  // Stability filter, acceptance pulses and message matcher; blank acceptance only moves r_acc.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand     <= BLANK;
      r_acc      <= BLANK;
      r_cnt      <= 8'd0;
      char_code  <= 4'd0;
      char_valid <= 1'b0;
      unknown    <= 1'b0;
      match      <= 1'b0;
      progress   <= 4'd0;
      msg_count  <= '0;
    end else begin
      r_cand     <= w_samp;
      r_cnt      <= w_cnt_nxt;
      char_valid <= w_ev;
      unknown    <= w_ev && w_code == 4'd15;
      match      <= w_ev && w_hit && w_last;
      if (w_accept) r_acc <= w_samp;
      if (w_ev) begin
        char_code <= w_code;
        progress  <= w_hit ? (w_last ? 4'd0 : progress + 4'd1) : (w_code == 4'd1 ? 4'd1 : 4'd0);
        if (w_hit && w_last && !(&msg_count)) msg_count <= msg_count + ONE;
      end
    end
  end
endmodule

// File: tb/tb_seg_msg_decoder.sv
// tb_seg_msg_decoder: directed vectors for the segment message decoder
module tb_seg_msg_decoder;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] seg_in;
  logic [3:0] char_code;
  logic       char_valid, unknown, match;
  logic [3:0] progress;
  logic [7:0] msg_count;
  int n_vec = 0, n_err = 0;
  int n_cv, n_m, n_u, n_mcv, n_ucv, first_cv, cyc;
  logic [7:0] msg [19] = '{8'h89, 8'hFF, 8'h86, 8'hFF, 8'hC7, 8'hFF, 8'hC7, 8'hFF, 8'hC0, 8'hFF,
                           8'hFF, 8'h88, 8'hFF, 8'h92, 8'hFF, 8'hCF, 8'hFF, 8'hC6, 8'hFF};
  seg_msg_decoder #(.STABLE_CYCLES(4), .COUNT_W(8)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .char_code(char_code), .char_valid(char_valid),
    .unknown(unknown), .match(match), .progress(progress), .msg_count(msg_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic clr;
    n_cv = 0; n_m = 0; n_u = 0; n_mcv = 0; n_ucv = 0; first_cv = -1; cyc = 0;
  endtask
  task automatic hold(input logic [7:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      seg_in = p;
      @(posedge clk);
      #1;
      if (char_valid) begin
        n_cv++;
        if (first_cv < 0) first_cv = cyc;
      end
      if (match) n_m++;
      if (unknown) n_u++;
      if (match && char_valid) n_mcv++;
      if (unknown && char_valid) n_ucv++;
      cyc++;
    end
  endtask
  task automatic send_msg(input int n);
    for (int k = 0; k < 19; k++) hold(msg[k], n);
  endtask
  initial begin
    reset = 1'b1;
    seg_in = 8'hFF;
    clr;
    hold(8'hFF, 10);
    check("rst_pulses", n_cv + n_m + n_u, 0);
    check("rst_char_code", char_code, 0);
    check("rst_progress", progress, 0);
    check("rst_msg_count", msg_count, 0);
    check("rst_char_valid", char_valid, 0);
    reset = 1'b0;
    clr;
    hold(8'h89, 20);
    check("h_events", n_cv, 1);
    check("h_latency", first_cv, 3);
    check("h_code", char_code, 1);
    check("h_progress", progress, 1);
    clr;
    hold(8'h86, 3);
    hold(8'hFF, 5);
    check("glitch_events", n_cv, 0);
    check("glitch_code", char_code, 1);
    check("glitch_progress", progress, 1);
    clr;
    send_msg(8);
    check("msg1_events", n_cv, 9);
    check("msg1_match", n_m, 1);
    check("msg1_match_with_cv", n_mcv, 1);
    check("msg1_code", char_code, 8);
    check("msg1_progress", progress, 0);
    check("msg1_count", msg_count, 1);
    clr;
    send_msg(8);
    check("msg2_match", n_m, 1);
    check("msg2_count", msg_count, 2);
    hold(8'h89, 8); hold(8'hFF, 8); hold(8'h86, 8); hold(8'hFF, 8); hold(8'hC7, 8); hold(8'hFF, 8);
    check("hel_progress", progress, 3);
    hold(8'h88, 8);
    check("hela_progress", progress, 0);
    hold(8'hFF, 8); hold(8'h89, 8); hold(8'hFF, 8); hold(8'h86, 8);
    check("he_progress", progress, 2);
    clr;
    hold(8'hFF, 8);
    hold(8'h80, 8);
    check("unk_pulses", n_u, 1);
    check("unk_with_cv", n_ucv, 1);
    check("unk_code", char_code, 15);
    check("unk_progress", progress, 0);
    hold(8'hFF, 8); hold(8'h89, 8); hold(8'hFF, 8); hold(8'h86, 8); hold(8'hFF, 8);
    hold(8'hC7, 8); hold(8'hFF, 8); hold(8'hC7, 8); hold(8'hFF, 8); hold(8'hC0, 8);
    check("pre_rst_progress", progress, 5);
    reset = 1'b1;
    clr;
    hold(8'hC0, 1);
    reset = 1'b0;
    check("mid_rst_pulses", n_cv + n_m + n_u, 0);
    check("mid_rst_progress", progress, 0);
    check("mid_rst_count", msg_count, 0);
    check("mid_rst_code", char_code, 0);
    clr;
    hold(8'hC0, 12);
    check("requal_events", n_cv, 1);
    check("requal_latency", first_cv, 3);
    check("requal_code", char_code, 4);
    check("requal_progress", progress, 0);
    clr;
    repeat (256) send_msg(5);
    check("sat_matches", n_m, 256);
    check("sat_count", msg_count, 255);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
